// File: rtl/pla_seq_eval.sv
// pla_seq_eval -- runtime-programmable sum-of-products evaluator.
//
// A cube table of N_CUBES entries (care mask, literal polarity, output mask,
// valid bit) is scanned one cube per clock for every accepted input vector;
// the result is the OR of the output masks of all matching cubes.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   cfg_we          write cube cfg_addr with cfg_care/cfg_val/cfg_out (IDLE only)
//   cfg_addr        cube index; indices >= N_CUBES are ignored
//   cfg_care        literal mask (1 = input appears in the cube)
//   cfg_val         literal polarity for cared inputs (1 = positive)
//   cfg_out         outputs driven by the cube
//   cfg_clr         invalidate every cube (IDLE only, wins over cfg_we)
//   busy            high whenever the evaluator is not idle
//   in_valid/in_ready/x    input vector handshake
//   out_valid/out_ready/f  result handshake; f is meaningful only with out_valid
module pla_seq_eval #(
    parameter int N_IN    = 8,
    parameter int N_OUT   = 7,
    parameter int N_CUBES = 16,
    parameter int AW      = $clog2(N_CUBES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [N_IN-1:0]   cfg_care,
    input  logic [N_IN-1:0]   cfg_val,
    input  logic [N_OUT-1:0]  cfg_out,
    input  logic              cfg_clr,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_OUT-1:0]  f
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [AW-1:0]      idx;
    logic [N_IN-1:0]    xr;
    logic [N_OUT-1:0]   acc;
    logic [N_CUBES-1:0] valid;

    logic [N_IN-1:0]    care_tab [N_CUBES];
    logic [N_IN-1:0]    val_tab  [N_CUBES];
    logic [N_OUT-1:0]   out_tab  [N_CUBES];

    logic               cfg_ok;
    logic               last;
    logic               hit;
    logic [N_OUT-1:0]   hit_out;

    // Config only lands while idle; writes in other states are dropped.
    always_comb begin
        cfg_ok  = (state == IDLE);
        last    = (idx == AW'(N_CUBES - 1));
        hit     = valid[idx] && (((xr ^ val_tab[idx]) & care_tab[idx]) == '0);
        hit_out = hit ? out_tab[idx] : '0;
    end

    // Table contents need no reset: the valid bits alone gate their use.
    // The address decode loop naturally drops out-of-range indices.
    always_ff @(posedge clk) begin
        if (cfg_ok && cfg_we && !cfg_clr) begin
            for (int unsigned i = 0; i < N_CUBES; i++) begin
                if (cfg_addr == AW'(i)) begin
                    care_tab[i] <= cfg_care;
                    val_tab[i]  <= cfg_val;
                    out_tab[i]  <= cfg_out;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (cfg_ok) begin
            if (cfg_clr) begin
                valid <= '0;
            end else if (cfg_we) begin
                for (int unsigned i = 0; i < N_CUBES; i++) begin
                    if (cfg_addr == AW'(i)) begin
                        valid[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = SCAN;
            SCAN:    if (last)     state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: latch on accept, accumulate one cube per SCAN cycle; the
    // final cube's contribution is folded straight into f on the last edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            acc <= '0;
            xr  <= '0;
            f   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        xr  <= x;
                        idx <= '0;
                        acc <= '0;
                    end
                end
                SCAN: begin
                    acc <= acc | hit_out;
                    if (last) begin
                        idx <= '0;
                        f   <= acc | hit_out;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pla_seq_eval.sv
// Self-checking bench for pla_seq_eval: a default-size instance checked
// against a cube-list reference model, plus a 3-cube instance.
module tb_pla_seq_eval;

    logic       clk = 1'b0;
    logic       rst_n;
    always #5 clk = ~clk;

    // Default-size instance (8 in, 7 out, 16 cubes)
    logic       cfg_we, cfg_clr, in_valid, out_ready;
    logic [3:0] cfg_addr;
    logic [7:0] cfg_care, cfg_val, x;
    logic [6:0] cfg_out, f;
    logic       busy, in_ready, out_valid;

    pla_seq_eval dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_care(cfg_care),
        .cfg_val(cfg_val), .cfg_out(cfg_out), .cfg_clr(cfg_clr),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .out_valid(out_valid), .out_ready(out_ready), .f(f)
    );

    // Small non-power-of-2 instance (4 in, 2 out, 3 cubes)
    logic       b_cfg_we, b_cfg_clr, b_in_valid, b_out_ready;
    logic [1:0] b_cfg_addr;
    logic [3:0] b_cfg_care, b_cfg_val, b_x;
    logic [1:0] b_cfg_out, b_f;
    logic       b_busy, b_in_ready, b_out_valid;

    pla_seq_eval #(.N_IN(4), .N_OUT(2), .N_CUBES(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr), .cfg_care(b_cfg_care),
        .cfg_val(b_cfg_val), .cfg_out(b_cfg_out), .cfg_clr(b_cfg_clr),
        .busy(b_busy), .in_valid(b_in_valid), .in_ready(b_in_ready), .x(b_x),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .f(b_f)
    );

    int tests = 0;
    int fails = 0;
    int edges = 0;
    logic [6:0] exp_f;

    // Reference model: a plain list of cubes
    logic [7:0] m_care [16];
    logic [7:0] m_val  [16];
    logic [6:0] m_out  [16];
    bit         m_valid[16];

    function automatic logic [6:0] model_f(input logic [7:0] v);
        logic [6:0] r = '0;
        for (int i = 0; i < 16; i++)
            if (m_valid[i] && ((v & m_care[i]) == (m_val[i] & m_care[i])))
                r = r | m_out[i];
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic cfg_write(input int a, input logic [7:0] c, input logic [7:0] v,
                             input logic [6:0] o, input bit upd);
        cfg_we = 1'b1; cfg_addr = 4'(a); cfg_care = c; cfg_val = v; cfg_out = o;
        tick();
        cfg_we = 1'b0;
        cfg_care = 8'($urandom); cfg_val = 8'($urandom); cfg_out = 7'($urandom);
        if (upd) begin
            m_care[a] = c; m_val[a] = v; m_out[a] = o; m_valid[a] = 1'b1;
        end
    endtask

    task automatic cfg_clear();
        cfg_clr = 1'b1;
        tick();
        cfg_clr = 1'b0;
        model_clear();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        check("in_ready_before_accept", in_ready, 1);
    endtask

    task automatic accept(input logic [7:0] v);
        wait_ready();
        in_valid = 1'b1; x = v;
        tick();
        in_valid = 1'b0;
        x = 8'($urandom);
        edges = 0;
        exp_f = model_f(v);
    endtask

    task automatic finish(input int hold);
        while (!out_valid && edges < 100) tick();
        check("latency", edges, 16);
        check("f", f, exp_f);
        for (int i = 0; i < hold; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_f", f, exp_f);
            check("bp_in_ready", in_ready, 0);
            check("bp_busy", busy, 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_hs_out_valid", out_valid, 0);
        check("post_hs_in_ready", in_ready, 1);
    endtask

    task automatic run(input logic [7:0] v, input int hold);
        accept(v);
        finish(hold);
    endtask

    task automatic b_cfg(input logic [1:0] a, input logic [3:0] c, input logic [3:0] v,
                         input logic [1:0] o);
        b_cfg_we = 1'b1; b_cfg_addr = a; b_cfg_care = c; b_cfg_val = v; b_cfg_out = o;
        tick();
        b_cfg_we = 1'b0;
    endtask

    task automatic b_run(input logic [3:0] v, input logic [1:0] e);
        int n = 0;
        while (!b_in_ready && n < 50) begin tick(); n++; end
        check("b_in_ready", b_in_ready, 1);
        b_in_valid = 1'b1; b_x = v;
        tick();
        b_in_valid = 1'b0; b_x = 4'($urandom);
        edges = 0;
        while (!b_out_valid && edges < 100) tick();
        check("b_latency", edges, 3);
        check("b_f", b_f, e);
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        check("b_post_hs_in_ready", b_in_ready, 1);
    endtask

    initial begin
        logic [7:0] c, v;
        int k;
        rst_n = 1'b0;
        cfg_we = 0; cfg_clr = 0; cfg_addr = '0; cfg_care = '0; cfg_val = '0; cfg_out = '0;
        in_valid = 0; out_ready = 0; x = '0;
        b_cfg_we = 0; b_cfg_clr = 0; b_cfg_addr = '0; b_cfg_care = '0; b_cfg_val = '0;
        b_cfg_out = '0; b_in_valid = 0; b_out_ready = 0; b_x = '0;
        model_clear();
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_f", f, 0);
        #9 rst_n = 1'b1;

        // misex1-f0 style product terms
        cfg_write(0, 8'h0F, 8'h05, 7'h01, 1);
        cfg_write(1, 8'h0F, 8'h0E, 7'h01, 1);
        run(8'h05, 0); check("misex_05", exp_f, 7'h01);
        run(8'h0E, 0); check("misex_0E", exp_f, 7'h01);
        run(8'h07, 0); check("misex_07", exp_f, 7'h00);

        // Overlapping cubes, with backpressure on the first result
        cfg_write(2, 8'h00, 8'h00, 7'h40, 1);
        run(8'h05, 5);
        run(8'hFF, 0);

        // Write during SCAN is dropped
        accept(8'h05);
        tick();
        check("busy_during_scan", busy, 1);
        cfg_write(3, 8'h00, 8'h00, 7'h7F, 0);
        finish(0);
        run(8'h07, 0);

        // Write coinciding with accept lands first
        wait_ready();
        cfg_we = 1; cfg_addr = 4'd5; cfg_care = 8'hFF; cfg_val = 8'h33; cfg_out = 7'h10;
        in_valid = 1; x = 8'h33;
        tick();
        cfg_we = 0; in_valid = 0; x = 8'($urandom);
        m_care[5] = 8'hFF; m_val[5] = 8'h33; m_out[5] = 7'h10; m_valid[5] = 1'b1;
        edges = 0;
        exp_f = model_f(8'h33);
        finish(0);

        // Simultaneous clear + write: clear wins
        cfg_clr = 1; cfg_we = 1; cfg_addr = 4'd6; cfg_care = 8'h00; cfg_out = 7'h7F;
        tick();
        cfg_clr = 0; cfg_we = 0;
        model_clear();
        run(8'h05, 0);
        run(8'hFF, 0);
        run(8'($urandom), 0);

        // Async reset mid-SCAN
        cfg_write(2, 8'h00, 8'h00, 7'h40, 1);
        run(8'h12, 0);
        accept(8'h05);
        for (int i = 0; i < 7; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_busy", busy, 0);
        check("arst_f", f, 0);
        #2 rst_n = 1'b1;
        model_clear();
        run(8'h05, 0);

        // Randomised phase
        for (int it = 0; it < 30; it++) begin
            k = $urandom_range(0, 9);
            if (k == 0) cfg_clear();
            else if (k < 7)
                cfg_write($urandom_range(0, 15), 8'($urandom & $urandom), 8'($urandom),
                          7'($urandom), 1);
            k = $urandom_range(0, 15);
            if (m_valid[k] && $urandom_range(0, 1) == 1) begin
                c = m_care[k]; v = m_val[k];
                accept((v & c) | (8'($urandom) & ~c));
            end else begin
                accept(8'($urandom));
            end
            if ($urandom_range(0, 2) == 0)
                cfg_write($urandom_range(0, 15), 8'h00, 8'h00, 7'($urandom), 0);
            finish($urandom_range(0, 2));
        end

        // 3-cube instance: out-of-range address is ignored, latency 3
        b_cfg(2'd0, 4'h3, 4'h1, 2'h1);
        b_cfg(2'd2, 4'h0, 4'h0, 2'h2);
        b_cfg(2'd3, 4'h0, 4'h0, 2'h1);
        b_run(4'h1, 2'h3);
        b_run(4'h2, 2'h2);
        b_run(4'h5, 2'h3);
        b_run(4'hE, 2'h2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
